// File: rtl/step_seq_pkg.sv
// rtl/step_seq_pkg.sv - shared types and constants for the step pattern sequencer
package step_seq_pkg;

   localparam int STEPS = 8;
   localparam int ROWS  = 8;

   typedef logic [ROWS-1:0] pattern_col_t;
   typedef logic [2:0]      step_idx_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   function automatic pattern_col_t toggle_bit(input pattern_col_t col, input step_idx_t row);
      return col ^ (pattern_col_t'(1) << row);
   endfunction

endpackage

// File: rtl/trig_stretch.sv
// rtl/trig_stretch.sv - holds a trigger word for TRIG_LEN cycles, restarting on every load
module trig_stretch
   import step_seq_pkg::*;
#(
   parameter int TRIG_LEN = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  pattern_col_t value,
   output pattern_col_t trig,
   output logic         trig_valid
);

   logic [3:0]   cnt_q, cnt_d;
   pattern_col_t trig_q, trig_d;
   logic         valid_q, valid_d;

   always_comb begin
      cnt_d   = cnt_q;
      trig_d  = trig_q;
      valid_d = valid_q;
      if (load) begin
         cnt_d   = 4'(TRIG_LEN);
         trig_d  = value;
         valid_d = |value;
      end else if (cnt_q == 4'd1) begin
         cnt_d   = 4'd0;
         trig_d  = '0;
         valid_d = 1'b0;
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q   <= 4'd0;
         trig_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         trig_q  <= trig_d;
         valid_q <= valid_d;
      end
   end

   assign trig       = trig_q;
   assign trig_valid = valid_q;

endmodule

// File: rtl/step_pattern_sequencer.sv
// rtl/step_pattern_sequencer.sv - 8x8 pad pattern sequencer; clear sweep gated by STEP_SEQ_CLEAR_EN
module step_pattern_sequencer
   import step_seq_pkg::*;
#(
   parameter int TRIG_LEN = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] step,
   input  logic       run,
   input  logic       btn_valid,
   input  logic [2:0] btn_row,
   input  logic [2:0] btn_col,
   input  logic       clear,
   output logic [7:0] col_bits,
   output logic [7:0] trig,
   output logic       trig_valid,
   output logic       busy
);

   pattern_col_t pattern_q [STEPS];
   step_idx_t    step_q;
   step_idx_t    idx_q;
   pattern_col_t col_bits_q;
   state_e       state_q;
   logic         busy_q;
   logic         load;

   // Reads pattern_q before this cycle's toggle lands, so a same-cycle press is not heard.
   assign load = (step != step_q) && run && (state_q == IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < STEPS; i++) pattern_q[i] <= '0;
         state_q <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (btn_valid) pattern_q[btn_col] <= toggle_bit(pattern_q[btn_col], btn_row);
`ifdef STEP_SEQ_CLEAR_EN
               if (clear) begin
                  state_q <= CLEAR;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
               end
`endif
            end
            CLEAR: begin
               pattern_q[idx_q] <= '0;
               idx_q            <= idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifndef STEP_SEQ_CLEAR_EN
   logic unused_clear;
   assign unused_clear = clear;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         step_q     <= '0;
         col_bits_q <= '0;
      end else begin
         step_q     <= step;
         col_bits_q <= pattern_q[step];
      end
   end

   trig_stretch #(
      .TRIG_LEN (TRIG_LEN)
   ) u_trig_stretch (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .value      (pattern_q[step]),
      .trig       (trig),
      .trig_valid (trig_valid)
   );

   assign col_bits = col_bits_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_step_pattern_sequencer.sv
// tb/tb_step_pattern_sequencer.sv - directed table and sequence checks for step_pattern_sequencer
module tb_step_pattern_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] step = '0;
   logic       run = 1'b0;
   logic       btn_valid = 1'b0;
   logic [2:0] btn_row = '0;
   logic [2:0] btn_col = '0;
   logic       clear = 1'b0;
   logic [7:0] col_bits;
   logic [7:0] trig;
   logic       trig_valid;
   logic       busy;

`ifdef STEP_SEQ_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   int total = 0;
   int bad   = 0;
   logic [7:0] model [8];

   typedef struct packed {
      logic [2:0] step;
      logic       run;
      logic       bv;
      logic [2:0] br;
      logic [2:0] bc;
      logic [7:0] ecol;
      logic [7:0] etrig;
   } vec_t;

   vec_t tbl [34];

   step_pattern_sequencer #(.TRIG_LEN(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .step       (step),
      .run        (run),
      .btn_valid  (btn_valid),
      .btn_row    (btn_row),
      .btn_col    (btn_col),
      .clear      (clear),
      .col_bits   (col_bits),
      .trig       (trig),
      .trig_valid (trig_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic readback(input string name);
      run = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step = 3'(c);
         tick();
         chk(name, col_bits, model[c]);
      end
   endtask

   initial begin
      tbl[0]  = '{3'd2, 1'b0, 1'b1, 3'd2, 3'd3, 8'h00, 8'h00};
      tbl[1]  = '{3'd2, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00};
      tbl[2]  = '{3'd3, 1'b1, 1'b0, 3'd0, 3'd0, 8'h04, 8'h04};
      tbl[3]  = '{3'd3, 1'b1, 1'b0, 3'd0, 3'd0, 8'h04, 8'h04};
      tbl[4]  = '{3'd3, 1'b1, 1'b0, 3'd0, 3'd0, 8'h04, 8'h04};
      tbl[5]  = '{3'd3, 1'b1, 1'b0, 3'd0, 3'd0, 8'h04, 8'h04};
      tbl[6]  = '{3'd3, 1'b1, 1'b1, 3'd0, 3'd4, 8'h04, 8'h00};
      tbl[7]  = '{3'd3, 1'b1, 1'b1, 3'd7, 3'd4, 8'h04, 8'h00};
      tbl[8]  = '{3'd3, 1'b1, 1'b1, 3'd4, 3'd5, 8'h04, 8'h00};
      tbl[9]  = '{3'd4, 1'b1, 1'b0, 3'd0, 3'd0, 8'h81, 8'h81};
      tbl[10] = '{3'd4, 1'b1, 1'b0, 3'd0, 3'd0, 8'h81, 8'h81};
      tbl[11] = '{3'd5, 1'b1, 1'b0, 3'd0, 3'd0, 8'h10, 8'h10};
      tbl[12] = '{3'd5, 1'b1, 1'b0, 3'd0, 3'd0, 8'h10, 8'h10};
      tbl[13] = '{3'd5, 1'b1, 1'b0, 3'd0, 3'd0, 8'h10, 8'h10};
      tbl[14] = '{3'd5, 1'b1, 1'b0, 3'd0, 3'd0, 8'h10, 8'h10};
      tbl[15] = '{3'd5, 1'b1, 1'b0, 3'd0, 3'd0, 8'h10, 8'h00};
      tbl[16] = '{3'd4, 1'b0, 1'b0, 3'd0, 3'd0, 8'h81, 8'h00};
      tbl[17] = '{3'd4, 1'b1, 1'b0, 3'd0, 3'd0, 8'h81, 8'h00};
      tbl[18] = '{3'd5, 1'b1, 1'b0, 3'd0, 3'd0, 8'h10, 8'h10};
      tbl[19] = '{3'd5, 1'b0, 1'b0, 3'd0, 3'd0, 8'h10, 8'h10};
      tbl[20] = '{3'd4, 1'b0, 1'b0, 3'd0, 3'd0, 8'h81, 8'h10};
      tbl[21] = '{3'd4, 1'b0, 1'b0, 3'd0, 3'd0, 8'h81, 8'h10};
      tbl[22] = '{3'd4, 1'b0, 1'b0, 3'd0, 3'd0, 8'h81, 8'h00};
      tbl[23] = '{3'd6, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00};
      tbl[24] = '{3'd7, 1'b1, 1'b1, 3'd0, 3'd7, 8'h00, 8'h00};
      tbl[25] = '{3'd7, 1'b1, 1'b0, 3'd0, 3'd0, 8'h01, 8'h00};
      tbl[26] = '{3'd7, 1'b1, 1'b1, 3'd5, 3'd0, 8'h01, 8'h00};
      tbl[27] = '{3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h20, 8'h20};
      tbl[28] = '{3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h20, 8'h20};
      tbl[29] = '{3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h20, 8'h20};
      tbl[30] = '{3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h20, 8'h20};
      tbl[31] = '{3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h20, 8'h00};
      tbl[32] = '{3'd0, 1'b1, 1'b1, 3'd5, 3'd0, 8'h20, 8'h00};
      tbl[33] = '{3'd0, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00};

      for (int c = 0; c < 8; c++) model[c] = 8'h00;

      tick();
      tick();
      chk("rst_col", col_bits, 8'h00);
      chk("rst_trig", trig, 8'h00);
      chk("rst_tv", {7'd0, trig_valid}, 8'h00);
      chk("rst_busy", {7'd0, busy}, 8'h00);
      rst = 1'b1;

      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_trig", trig, 8'h00);
         chk("idle_col", col_bits, 8'h00);
         chk("idle_busy", {7'd0, busy}, 8'h00);
      end

      for (int i = 0; i < 34; i++) begin
         step      = tbl[i].step;
         run       = tbl[i].run;
         btn_valid = tbl[i].bv;
         btn_row   = tbl[i].br;
         btn_col   = tbl[i].bc;
         tick();
         if (tbl[i].bv) model[tbl[i].bc][tbl[i].br] = ~model[tbl[i].bc][tbl[i].br];
         chk($sformatf("vec%0d_col", i), col_bits, tbl[i].ecol);
         chk($sformatf("vec%0d_trig", i), trig, tbl[i].etrig);
         chk($sformatf("vec%0d_tv", i), {7'd0, trig_valid}, {7'd0, |tbl[i].etrig});
         chk($sformatf("vec%0d_busy", i), {7'd0, busy}, 8'h00);
      end
      btn_valid = 1'b0;

      // Fill every cell, then sweep-clear with a dropped press and a step change mid-sweep.
      run  = 1'b0;
      step = 3'd0;
      for (int c = 0; c < 8; c++) begin
         for (int r = 0; r < 8; r++) begin
            if (!model[c][r]) begin
               btn_valid = 1'b1;
               btn_row   = 3'(r);
               btn_col   = 3'(c);
               tick();
               model[c][r] = 1'b1;
            end
         end
      end
      btn_valid = 1'b0;
      readback("full_col");

      run = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         clear     = (k <= 1);
         btn_valid = (k == 2);
         btn_row   = 3'd1;
         btn_col   = 3'd7;
         if (k == 3) step = 3'd0;
         tick();
         if (k == 2 && !CLR_EN) model[7][1] = 1'b0;
         chk($sformatf("sweep%0d_busy", k), {7'd0, busy}, {7'd0, CLR_EN && k <= 7});
         chk($sformatf("sweep%0d_trig", k), trig, (!CLR_EN && k >= 3 && k <= 6) ? 8'hFF : 8'h00);
      end
      clear     = 1'b0;
      btn_valid = 1'b0;
      if (CLR_EN) for (int c = 0; c < 8; c++) model[c] = 8'h00;
      readback("after_clear_col");

      btn_valid = 1'b1;
      btn_row   = 3'd6;
      btn_col   = 3'd1;
      tick();
      model[1][6] = ~model[1][6];
      btn_valid = 1'b0;
      for (int k = 0; k <= 3; k++) begin
         clear = (k == 0);
         tick();
         chk($sformatf("rsweep%0d_busy", k), {7'd0, busy}, {7'd0, CLR_EN});
      end
      clear = 1'b0;
      rst   = 1'b0;
      tick();
      chk("midrst_busy", {7'd0, busy}, 8'h00);
      chk("midrst_col", col_bits, 8'h00);
      chk("midrst_trig", trig, 8'h00);
      rst = 1'b1;
      for (int c = 0; c < 8; c++) model[c] = 8'h00;
      readback("after_rst_col");
      tick();
      chk("final_busy", {7'd0, busy}, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/step_pattern_sequencer.md
# step_pattern_sequencer

Downstream consumer of the 3-bit, 8-state step counter. It holds an 8×8 pad pattern: 8 steps (columns) × 8 rows. Pad presses toggle cells in the pattern. On every step change it emits per-row trigger pulses to the tone/LED stage and shows the current column on the pad LEDs.

## Interface
Parameters:
- TRIG_LEN, default 1: width of each trigger pulse in clk cycles; legal range 1..15.

Ports:
- clk  in  1  system clock; every register is clocked on the rising edge.
- rst  in  1  reset, synchronous and active-low: sampled on the clk rising edge, and rst=0 resets the block.
- step  in  3  current step index from the upstream 8-step counter.
- run  in  1  playback enable; 0 suppresses new triggers.
- btn_valid  in  1  one-cycle pad-press strobe.
- btn_row  in  3  row of the pressed pad.
- btn_col  in  3  column (step) of the pressed pad.
- clear  in  1  request to clear the whole pattern.
- col_bits  out  8  registered pattern column for the current step; bit r is row r.
- trig  out  8  per-row trigger pulses.
- trig_valid  out  1  high while trig is non-zero.
- busy  out  1  high while a clear sweep is in progress.

## Operation
- Storage: 8 registers, pattern[0..7], each 8 bits wide, indexed by column. All are 0 at reset.
- Toggle: a cycle with btn_valid=1 in state IDLE inverts pattern[btn_col][btn_row]. Presses in state CLEAR are dropped.
- Step change: a registered step_q holds the previous step; a change is declared when step != step_q. Any difference counts as a change, including 7→0 wrap and non-sequential jumps.
- Trigger conditions: a change with run=1 in state IDLE loads trig with pattern[step].
  - trig is then held for TRIG_LEN cycles and cleared afterwards.
  - A new change during the hold reloads trig and restarts the count.
  - If pattern[step] is 0, trig stays 0 and trig_valid stays 0.
- Simultaneous events: if a toggle and a step change land in the same cycle, trig uses the pattern value from before the toggle. The toggle becomes visible the next cycle.
- run: a 0→1 transition does not trigger by itself; the next step change does. Clearing run mid-hold lets the current pulse finish.
- State machine, states IDLE and CLEAR:
  - IDLE→CLEAR when clear=1.
  - In CLEAR, a 3-bit index sweeps 0..7 and zeroes pattern[idx] once per cycle, so the sweep takes 8 cycles. On idx=7 the block returns to IDLE.
  - busy=1 exactly in CLEAR.
  - clear=1 while in CLEAR is ignored, and no triggers are loaded during CLEAR.
- Reset mid-operation: with rst=0 on any cycle, the next state is IDLE with every register at its reset value.

## Timing
- Reset values: col_bits=0, trig=0, trig_valid=0, busy=0, step_q=0, state IDLE, hold counter 0.
- Step change sampled at edge N: trig and trig_valid are valid from cycle N+1 through N+TRIG_LEN.
- col_bits = pattern[step] registered, giving 1-cycle latency. It reflects a toggle or a clear of the displayed column one cycle after the write.
- Clear: with clear=1 sampled at edge N, busy is high for cycles N+1..N+8. The block is back in IDLE at N+9.

## Configuration
- STEP_SEQ_CLEAR_EN defined: the clear sweep FSM and busy are implemented as described above.
- STEP_SEQ_CLEAR_EN not defined:
  - The clear input is ignored and busy is tied to 0.
  - The block behaves as permanently IDLE.
  - Both ports remain present.

## Structure
- Package step_seq_pkg holds:
  - constants STEPS=8 and ROWS=8;
  - the state enum {IDLE, CLEAR};
  - the typedefs pattern_col_t (8-bit) and step_idx_t (3-bit).
- Sub-module trig_stretch holds the TRIG_LEN hold counter and the load/restart logic:
  - inputs: clk, rst, load, value;
  - outputs: trig, trig_valid.

## Test plan
- Reset, then step stays 0 for 20 cycles → trig=0, col_bits=0, busy=0 throughout.
- Toggle (row 2, col 3), set run=1, then step 2→3 → col_bits=0x04 one cycle after the change; trig=0x04 for exactly TRIG_LEN cycles.
- With TRIG_LEN=4, step changes 3→4 and then 4→5 two cycles later, with pattern[4]=0x81 and pattern[5]=0x10 → trig=0x81 for 2 cycles, then 0x10 for 4 cycles.
- Toggle (row 0, col 7) in the same cycle as step 6→7, with pattern[7]=0 beforehand → trig stays 0; col_bits=0x01 on the next cycle.
- clear=1 with all cells set, a btn_valid press during the sweep, and a step change → busy high for 8 cycles, no trig, the press dropped, and all pattern registers 0 afterwards.
- rst=0 asserted on the 4th cycle of a clear sweep → IDLE and busy=0 the next cycle; all col_bits read 0.
